hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter DATA_W, default 16: width of every forwarded data word.
REQ-002 Parameter NUM_REGS, default 8: architectural register count; REG_W = clog2(NUM_REGS).
REQ-003 Parameter DEPTH, default 3: tracked stages after issue (1=EX, 2=MEM, 3=WB); SEL_W = clog2(DEPTH+1).
REQ-004 Parameter LOAD_STG, default 2: first stage where load data is valid; 1 <= LOAD_STG <= DEPTH.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 iss_valid  input  1  decode holds an instruction requesting issue.
REQ-008 iss_wr / iss_load  input  1 each  issuing instruction writes a register / is a load.
REQ-009 iss_dst  input  REG_W  destination register of the issuing instruction.
REQ-010 src_a, src_b  input  REG_W each  source registers; use_a, use_b  input  1 each  source is read.
REQ-011 ext_stall  input  1  global freeze (data-memory stall); no stage advances.
REQ-012 flush  input  1  kill the issuing instruction and stage 1.
REQ-013 stg_data  input  DEPTH*DATA_W  result of stage k in bits [k*DATA_W-1 -: DATA_W].
REQ-014 rf_a, rf_b  input  DATA_W each  register-file read data.
REQ-015 fwd_a_sel, fwd_b_sel  output  SEL_W each  0 = register file, k = stage k.
REQ-016 fwd_a_data, fwd_b_data  output  DATA_W each  operand selected by fwd_*_sel.
REQ-017 stall  output  1  hazard stall; hold decode, insert bubble.
REQ-018 err  output  1  illegal-combination flag, ORed into the processor err.

Function
REQ-019 Per-stage record {valid, wr, load, dst}; stage k+1 takes stage k each cycle when ext_stall=0.
REQ-020 Issue accepted = iss_valid & ~stall & ~ext_stall & ~flush; stage 1 loads the issuing record if accepted, else a bubble (valid=0).
REQ-021 Match on stage k: valid & wr & dst==src & use; among matches the lowest k (youngest) wins.
REQ-022 Winning match is forwardable when load=0, or when k >= LOAD_STG.
REQ-023 Forwardable winner: fwd_*_sel=k, fwd_*_data=stage-k slice; no match: sel=0, data=rf_*.
REQ-024 stall = iss_valid & (winner on A or B not forwardable); combinational, same cycle.
REQ-025 ext_stall=1: all records hold, stall still computed from held records, no issue accepted.
REQ-026 flush=1 with ext_stall=0: stage 1 becomes a bubble next cycle, older stages advance normally.
REQ-027 flush=1 with ext_stall=1: flush is ignored for state; the stage 1 record holds.
REQ-028 A record leaving stage DEPTH is dropped; the register file holds the value thereafter.
REQ-029 err=1 when iss_valid & iss_load & ~iss_wr, or flush & ext_stall; combinational.

Reset
REQ-030 rst low clears every valid bit immediately; other record fields are don't-care.
REQ-031 During and after reset until a record exists: stall=0, fwd_*_sel=0, fwd_*_data=rf_*, err follows inputs only.
REQ-032 Reset asserted mid-stall discards all in-flight records; the first issue after release sees no hazards.

Configuration
REQ-033 Macro HZD_FWD_EN defined: forwarding behaves per REQ-022/023.
REQ-034 HZD_FWD_EN undefined: fwd_*_sel=0 always; any match in stages 1..DEPTH-1 raises stall; a stage-DEPTH match uses rf_* (write-before-read register file).

Structure
REQ-035 Shared package hzd_pkg holds the stage-record typedef, SEL_W/REG_W derivation functions and the default parameter constants.
REQ-036 One sub-module, hzd_match, SHALL compute winner/forwardable per source; instantiated twice (A, B).

Verification
REQ-037 ALU back-to-back: issue ADD r3, then use_a=1 src_a=3 -> stall=0, fwd_a_sel=1, fwd_a_data=stage-1 data (0x1234).
REQ-038 Load-use: issue LD r2, next src_b=2 -> stall=1 one cycle, then fwd_b_sel=2, data=stage-2 load value (0xBEEF).
REQ-039 Youngest wins: r5 written at stages 1 and 3 (0x0001/0x0003) -> fwd_a_sel=1, data=0x0001.
REQ-040 ext_stall=1 for 4 cycles holding LD r4 at stage 2 -> records frozen, stall stays 0 for src r4, fwd_sel=2 throughout.
REQ-041 flush with ADD r6 in stage 1 -> next cycle src r6 gives sel=0, data=rf_a; flush & ext_stall -> err=1.
REQ-042 HZD_FWD_EN undefined: ADD r1 then use r1 -> stall=1 for DEPTH-1=2 cycles, then sel=0, data=rf.

Source files
------------

// File: rtl/hzd_pkg.sv
// hzd_pkg: stage-record type, width helpers and default parameters shared by hazard_scoreboard
package hzd_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_DEPTH    = 3;
    localparam int DEF_LOAD_STG = 2;
    localparam int MAX_REG_W    = 8;

    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic                 load;
        logic [MAX_REG_W-1:0] dst;
    } hzd_rec_t;

    function automatic int reg_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sel_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/hzd_match.sv
// hzd_match: youngest-match search and forwardability for one source operand (FWD selects HZD_FWD_EN behaviour)
module hzd_match
    import hzd_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int LOAD_STG = DEF_LOAD_STG,
    parameter int SEL_W    = 2,
    parameter bit FWD      = 1'b0
) (
    input  hzd_rec_t [DEPTH:1]     i_recs,
    input  logic [MAX_REG_W-1:0]   i_src,
    input  logic                   i_use,
    output logic                   o_block,
    output logic [SEL_W-1:0]       o_sel
);

    logic w_hit;
    logic w_load;
    int   w_k;

    // scan oldest to youngest so the lowest matching stage overwrites older ones
    always_comb begin
        w_hit  = 1'b0;
        w_load = 1'b0;
        w_k    = 0;
        for (int k = DEPTH; k >= 1; k--)
            if (i_use && i_recs[k].valid && i_recs[k].wr && i_recs[k].dst == i_src) begin
                w_hit  = 1'b1;
                w_load = i_recs[k].load;
                w_k    = k;
            end
    end

    // without forwarding only the last stage is safe, since the register file writes before it is read
    assign o_block = FWD ? (w_hit && w_load && w_k < LOAD_STG) : (w_hit && w_k < DEPTH);
    assign o_sel   = (FWD && w_hit && !o_block) ? SEL_W'(w_k) : '0;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight register-write tracking with stall and forwarding select; HZD_FWD_EN enables forwarding
module hazard_scoreboard
    import hzd_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int LOAD_STG = DEF_LOAD_STG,
    localparam int REG_W   = reg_w(NUM_REGS),
    localparam int SEL_W   = sel_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_valid,
    input  logic                    iss_wr,
    input  logic                    iss_load,
    input  logic [REG_W-1:0]        iss_dst,
    input  logic [REG_W-1:0]        src_a,
    input  logic [REG_W-1:0]        src_b,
    input  logic                    use_a,
    input  logic                    use_b,
    input  logic                    ext_stall,
    input  logic                    flush,
    input  logic [DEPTH*DATA_W-1:0] stg_data,
    input  logic [DATA_W-1:0]       rf_a,
    input  logic [DATA_W-1:0]       rf_b,
    output logic [SEL_W-1:0]        fwd_a_sel,
    output logic [SEL_W-1:0]        fwd_b_sel,
    output logic [DATA_W-1:0]       fwd_a_data,
    output logic [DATA_W-1:0]       fwd_b_data,
    output logic                    stall,
    output logic                    err
);

`ifdef HZD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    hzd_rec_t [DEPTH:1] r_recs;
    hzd_rec_t           w_iss;
    logic               w_block_a;
    logic               w_block_b;
    logic               w_accept;

    assign w_iss    = hzd_rec_t'{valid: 1'b1, wr: iss_wr, load: iss_load, dst: MAX_REG_W'(iss_dst)};
    assign stall    = iss_valid && (w_block_a || w_block_b);
    assign w_accept = iss_valid && !stall && !ext_stall && !flush;
    assign err      = (iss_valid && iss_load && !iss_wr) || (flush && ext_stall);

    hzd_match #(.DEPTH(DEPTH), .LOAD_STG(LOAD_STG), .SEL_W(SEL_W), .FWD(FWD)) u_match_a (
        .i_recs  (r_recs),
        .i_src   (MAX_REG_W'(src_a)),
        .i_use   (use_a),
        .o_block (w_block_a),
        .o_sel   (fwd_a_sel)
    );

    hzd_match #(.DEPTH(DEPTH), .LOAD_STG(LOAD_STG), .SEL_W(SEL_W), .FWD(FWD)) u_match_b (
        .i_recs  (r_recs),
        .i_src   (MAX_REG_W'(src_b)),
        .i_use   (use_b),
        .o_block (w_block_b),
        .o_sel   (fwd_b_sel)
    );

    // operand mux: register file unless a stage is selected
    always_comb begin
        fwd_a_data = rf_a;
        fwd_b_data = rf_b;
        for (int k = 1; k <= DEPTH; k++) begin
            if (fwd_a_sel == SEL_W'(k)) fwd_a_data = stg_data[k*DATA_W-1 -: DATA_W];
            if (fwd_b_sel == SEL_W'(k)) fwd_b_data = stg_data[k*DATA_W-1 -: DATA_W];
        end
    end

    // advance records; flush kills the issuer and the stage-1 record, ext_stall freezes everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_recs <= '0;
        end else if (!ext_stall) begin
            r_recs[1] <= w_accept ? w_iss : hzd_rec_t'(0);
            for (int k = 2; k <= DEPTH; k++)
                r_recs[k] <= (k == 2 && flush) ? hzd_rec_t'(0) : r_recs[k-1];
        end
    end

endmodule
